cplx_alu: RTL and testbench

Sequencer and arithmetic unit sitting directly upstream of the 32×16 complex data memory. On a start command it reads two packed complex operands through the memory's two asynchronous read ports, computes add, subtract, multiply or conjugate-multiply, and writes the saturated result back through the memory's single write port. It is the compute stage between the controller issuing `op/src/dst` commands and the data memory.

---
 rtl/cplx_alu.sv | 202 ++++++++++++++++++++
 tb/tb_cplx_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_alu.sv
// cplx_alu: command sequencer + complex ALU (add/sub/mul/conj-mul) over a
// 2-read/1-write complex memory.
// Ports: clk, rst (sync, active-high); start/op/src0_addr/src1_addr/dst_addr
//   command; read_address0/1 + read_data0/1 memory reads; write,
//   write_address, write_data memory write; busy, done, ovf status.
module cplx_alu #(
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [AW-1:0]   src0_addr,
  input  logic [AW-1:0]   src1_addr,
  input  logic [AW-1:0]   dst_addr,
  output logic [AW-1:0]   read_address0,
  output logic [AW-1:0]   read_address1,
  input  logic [2*W-1:0]  read_data0,
  input  logic [2*W-1:0]  read_data1,
  output logic            write,
  output logic [AW-1:0]   write_address,
  output logic [2*W-1:0]  write_data,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_EXEC,
    S_MUL0, S_MUL1, S_MUL2, S_MUL3,
    S_WRITE, S_DONE
  } state_t;

  localparam logic signed [2*W:0] SMAX = (2*W+1)'(2**(W-1) - 1);
  localparam logic signed [2*W:0] SMIN = -(2*W+1)'(2**(W-1));

  state_t state_q, state_d;

  logic [1:0]            op_q, op_d;
  logic [AW-1:0]         src0_q, src0_d;
  logic [AW-1:0]         src1_q, src1_d;
  logic [AW-1:0]         dst_q, dst_d;
  logic signed [W-1:0]   ar_q, ar_d, ai_q, ai_d;
  logic signed [W-1:0]   br_q, br_d, bi_q, bi_d;
  logic signed [2*W:0]   re_q, re_d, im_q, im_d;
  logic                  ovf_q, ovf_d;

  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   prod_x;
  logic signed [W:0]     sum_re, sum_im;
  logic [W-1:0]          re_sat, im_sat;
  logic                  re_clip, im_clip;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      dst_q   <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      re_q    <= '0;
      im_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      dst_q   <= dst_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      re_q    <= re_d;
      im_q    <= im_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = op_q[1] ? S_MUL0 : S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_MUL0:  state_d = S_MUL1;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_MUL3;
      S_MUL3:  state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared multiplier: operand pair chosen by the MULx step
  always_comb begin
    mul_a = ar_q;
    mul_b = br_q;
    unique case (state_q)
      S_MUL1:  begin mul_a = ai_q; mul_b = bi_q; end
      S_MUL2:  begin mul_a = ar_q; mul_b = bi_q; end
      S_MUL3:  begin mul_a = ai_q; mul_b = br_q; end
      default: begin mul_a = ar_q; mul_b = br_q; end
    endcase
    prod   = mul_a * mul_b;
    prod_x = {prod[2*W-1], prod};
  end

  // W+1-bit add/sub cannot wrap
  always_comb begin
    if (op_q[0]) begin
      sum_re = {ar_q[W-1], ar_q} - {br_q[W-1], br_q};
      sum_im = {ai_q[W-1], ai_q} - {bi_q[W-1], bi_q};
    end else begin
      sum_re = {ar_q[W-1], ar_q} + {br_q[W-1], br_q};
      sum_im = {ai_q[W-1], ai_q} + {bi_q[W-1], bi_q};
    end
  end

  // Clamp each accumulator to the signed W-bit range
  always_comb begin
    re_clip = 1'b1;
    im_clip = 1'b1;
    if (re_q > SMAX)      re_sat = {1'b0, {(W-1){1'b1}}};
    else if (re_q < SMIN) re_sat = {1'b1, {(W-1){1'b0}}};
    else begin
      re_sat  = re_q[W-1:0];
      re_clip = 1'b0;
    end
    if (im_q > SMAX)      im_sat = {1'b0, {(W-1){1'b1}}};
    else if (im_q < SMIN) im_sat = {1'b1, {(W-1){1'b0}}};
    else begin
      im_sat  = im_q[W-1:0];
      im_clip = 1'b0;
    end
  end

  // Datapath register updates
  always_comb begin
    op_d   = op_q;
    src0_d = src0_q;
    src1_d = src1_q;
    dst_d  = dst_q;
    ar_d   = ar_q;
    ai_d   = ai_q;
    br_d   = br_q;
    bi_d   = bi_q;
    re_d   = re_q;
    im_d   = im_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          src0_d = src0_addr;
          src1_d = src1_addr;
          dst_d  = dst_addr;
          ovf_d  = 1'b0;
        end
      end
      S_LOAD: begin
        ar_d = read_data0[2*W-1:W];
        ai_d = read_data0[W-1:0];
        br_d = read_data1[2*W-1:W];
        bi_d = read_data1[W-1:0];
      end
      S_EXEC: begin
        re_d = {{W{sum_re[W]}}, sum_re};
        im_d = {{W{sum_im[W]}}, sum_im};
      end
      S_MUL0: re_d = prod_x;
      // MULC adds ai*bi and negates ar*bi
      S_MUL1: re_d = op_q[0] ? re_q + prod_x : re_q - prod_x;
      S_MUL2: im_d = op_q[0] ? -prod_x : prod_x;
      S_MUL3: im_d = im_q + prod_x;
      S_WRITE: ovf_d = re_clip | im_clip;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    read_address0 = src0_q;
    read_address1 = src1_q;
    write_address = dst_q;
    write_data    = {re_sat, im_sat};
    write         = (state_q == S_WRITE);
    done          = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
    ovf           = ovf_q;
  end

endmodule

// File: tb/tb_cplx_alu.sv
// tb_cplx_alu: directed bench for cplx_alu with a memory model and
// arithmetic reference model checked every cycle.
module tb_cplx_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  src0 = '0, src1 = '0, dst = '0;
  logic [4:0]  ra0, ra1, wa;
  logic [15:0] rd0, rd1, wd;
  logic        wr, busy, done, ovf;

  logic [15:0] mem     [32];
  logic [15:0] ref_mem [32];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   checking = 1'b0;
  bit   pending = 1'b0;
  int   e0 = 0;
  int   woff = 0;
  logic [15:0] cmd_data = '0;
  logic [4:0]  cmd_addr = '0, cmd_s0 = '0, cmd_s1 = '0;
  logic        cmd_ovf = 1'b0;
  logic        held_ovf = 1'b0;

  cplx_alu #(.W(8), .AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src0_addr(src0), .src1_addr(src1), .dst_addr(dst),
    .read_address0(ra0), .read_address1(ra1),
    .read_data0(rd0), .read_data1(rd1),
    .write(wr), .write_address(wa), .write_data(wd),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr) mem[wa] <= wd;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: complex arithmetic on integers, then clamp to -128..127
  function automatic logic [16:0] model(input logic [1:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int ar, ai, br, bi, re, im;
    logic ov;
    logic [7:0] r8, i8;
    ar = int'($signed(a[15:8]));
    ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8]));
    bi = int'($signed(b[7:0]));
    case (o)
      2'd0:    begin re = ar + br; im = ai + bi; end
      2'd1:    begin re = ar - br; im = ai - bi; end
      2'd2:    begin re = ar*br - ai*bi; im = ar*bi + ai*br; end
      default: begin re = ar*br + ai*bi; im = ai*br - ar*bi; end
    endcase
    ov = 1'b0;
    if (re > 127) begin re = 127; ov = 1'b1; end
    else if (re < -128) begin re = -128; ov = 1'b1; end
    if (im > 127) begin im = 127; ov = 1'b1; end
    else if (im < -128) begin im = -128; ov = 1'b1; end
    r8 = re[7:0];
    i8 = im[7:0];
    return {ov, r8, i8};
  endfunction

  // Cycle-by-cycle comparison against the expected command schedule
  always @(negedge clk) begin : cmp
    bit ew, ed, eo;
    if (checking && !rst) begin
      ew = pending && (cyc == e0 + woff);
      ed = pending && (cyc == e0 + woff + 1);
      if (pending) eo = (cyc >= e0 + woff + 1) ? cmd_ovf : 1'b0;
      else         eo = held_ovf;
      chk("busy", 32'(busy), 32'(pending));
      chk("write", 32'(wr), 32'(ew));
      chk("done", 32'(done), 32'(ed));
      chk("ovf", 32'(ovf), 32'(eo));
      if (pending) begin
        chk("read_address0", 32'(ra0), 32'(cmd_s0));
        chk("read_address1", 32'(ra1), 32'(cmd_s1));
      end
      if (ew) begin
        chk("write_address", 32'(wa), 32'(cmd_addr));
        chk("write_data", 32'(wd), 32'(cmd_data));
        ref_mem[cmd_addr] = cmd_data;
      end
      if (ed) begin
        pending  = 1'b0;
        held_ovf = cmd_ovf;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (pending && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pending) begin
      errors++;
      $display("FAIL timeout: command still pending at cycle %0d", cyc);
      pending = 1'b0;
    end
  endtask

  // Start is raised in the first cycle allowed; returns 2 time units after edge 0
  task automatic issue(input logic [1:0] o, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [4:0] d);
    logic [16:0] m;
    wait_idle();
    @(posedge clk);
    #2;
    op = o; src0 = s0; src1 = s1; dst = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    m = model(o, ref_mem[s0], ref_mem[s1]);
    e0       = cyc;
    woff     = o[1] ? 5 : 2;
    cmd_data = m[15:0];
    cmd_ovf  = m[16];
    cmd_addr = d;
    cmd_s0   = s0;
    cmd_s1   = s1;
    pending  = 1'b1;
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0102;
    mem[1] = 16'h0304;
    mem[2] = 16'h0001;
    mem[3] = 16'h0100;
    mem[8] = 16'h6464;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset write", 32'(wr), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset ra0", 32'(ra0), 32'd0);
    chk("reset ra1", 32'(ra1), 32'd0);
    chk("reset wa", 32'(wa), 32'd0);
    chk("reset wd", 32'(wd), 32'd0);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    issue(2'd0, 5'd0, 5'd1, 5'd4);
    issue(2'd2, 5'd0, 5'd1, 5'd5);
    issue(2'd3, 5'd0, 5'd1, 5'd6);
    issue(2'd2, 5'd2, 5'd2, 5'd7);
    issue(2'd1, 5'd3, 5'd0, 5'd0);
    issue(2'd0, 5'd0, 5'd3, 5'd11);
    wait_idle();
    @(posedge clk);
    #2;
    chk("mem4 add", 32'(mem[4]), 32'h0406);
    chk("mem5 mul", 32'(mem[5]), 32'hFB0A);
    chk("mem6 mulc", 32'(mem[6]), 32'h0B02);
    chk("mem7 i*i", 32'(mem[7]), 32'hFF00);
    chk("mem0 sub dst=src", 32'(mem[0]), 32'h00FE);
    chk("mem11 reads new", 32'(mem[11]), 32'h01FE);

    issue(2'd0, 5'd8, 5'd8, 5'd9);
    wait_idle();
    @(posedge clk);
    #2;
    chk("mem9 add sat", 32'(mem[9]), 32'h7F7F);
    chk("ovf add sat held", 32'(ovf), 32'd1);

    issue(2'd2, 5'd8, 5'd8, 5'd10);
    wait_idle();
    @(posedge clk);
    #2;
    chk("mem10 mul sat", 32'(mem[10]), 32'h007F);
    chk("ovf mul sat held", 32'(ovf), 32'd1);

    // Second start while busy must be ignored
    issue(2'd0, 5'd1, 5'd2, 5'd12);
    @(posedge clk);
    #2;
    dst = 5'd13;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle();
    @(posedge clk);
    #2;
    chk("mem12 add", 32'(mem[12]), 32'h0305);
    chk("mem13 untouched", 32'(mem[13]), 32'h0000);

    // Reset in MUL2
    issue(2'd2, 5'd1, 5'd1, 5'd14);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    pending  = 1'b0;
    held_ovf = 1'b0;
    chk("busy after reset", 32'(busy), 32'd0);
    chk("write after reset", 32'(wr), 32'd0);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("mem14 after abort", 32'(mem[14]), 32'h0000);

    issue(2'd2, 5'd1, 5'd1, 5'd14);
    wait_idle();
    @(posedge clk);
    #2;
    chk("mem14 mul", 32'(mem[14]), 32'hF918);

    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i),
                                     32'(mem[i]), 32'(ref_mem[i]));

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
